// File: rtl/tx_streamer.sv
`default_nettype none
// ============================================================================
// tx_streamer: splits one RDMA WRITE request into MTU fragments, emitting a
// header descriptor and an MM2S read command per fragment.
// Revision: 1.0
// ============================================================================
module tx_streamer #(
    parameter int          C_ADDR_WIDTH            = 32,
    parameter int          C_BTT_WIDTH             = 23,
    parameter int          RDMA_ADDR_WIDTH         = 64,
    parameter int          RDMA_RKEY_WIDTH         = 32,
    parameter int          RDMA_LENGTH_WIDTH       = 32,
    parameter int          OFFSET_LENGTH           = 16,
    parameter int          MTU_BYTES               = 1024,
    parameter logic [7:0]  RDMA_OPCODE_WRITE_FIRST  = 8'h06,
    parameter logic [7:0]  RDMA_OPCODE_WRITE_MIDDLE = 8'h07,
    parameter logic [7:0]  RDMA_OPCODE_WRITE_LAST   = 8'h08,
    parameter logic [7:0]  RDMA_OPCODE_WRITE_ONLY   = 8'h0A
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [C_ADDR_WIDTH-1:0]      cmd_local_addr,
    input  logic [RDMA_ADDR_WIDTH-1:0]   cmd_remote_addr,
    input  logic [RDMA_RKEY_WIDTH-1:0]   cmd_rkey,
    input  logic [RDMA_LENGTH_WIDTH-1:0] cmd_length,
    output logic                         hdr_valid,
    input  logic                         hdr_ready,
    output logic [7:0]                   hdr_opcode,
    output logic [RDMA_ADDR_WIDTH-1:0]   hdr_remote_addr,
    output logic [RDMA_RKEY_WIDTH-1:0]   hdr_rkey,
    output logic [RDMA_LENGTH_WIDTH-1:0] hdr_length,
    output logic [OFFSET_LENGTH-1:0]     hdr_fragment_offset,
    output logic [71:0]                  m_axis_mm2s_cmd_tdata,
    output logic                         m_axis_mm2s_cmd_tvalid,
    input  logic                         m_axis_mm2s_cmd_tready,
    input  logic                         mm2s_rd_xfer_cmplt,
    output logic [2:0]                   tx_state,
    output logic                         tx_active,
    output logic                         write_started,
    output logic                         write_done,
    output logic                         length_error
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CHECK      = 3'd1,
        S_PREPARE    = 3'd2,
        S_SEND_HDR   = 3'd3,
        S_ISSUE_CMD  = 3'd4,
        S_WAIT_CMPLT = 3'd5,
        S_DONE       = 3'd6,
        S_ERROR      = 3'd7
    } state_t;

    localparam logic [RDMA_LENGTH_WIDTH-1:0] c_mtu     = RDMA_LENGTH_WIDTH'(MTU_BYTES);
    localparam logic [RDMA_LENGTH_WIDTH-1:0] c_max_len = RDMA_LENGTH_WIDTH'(64'd1 << OFFSET_LENGTH);

    state_t                         state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]        local_addr_q, local_addr_d;
    logic [RDMA_ADDR_WIDTH-1:0]     remote_addr_q, remote_addr_d;
    logic [RDMA_RKEY_WIDTH-1:0]     rkey_q, rkey_d;
    logic [RDMA_LENGTH_WIDTH-1:0]   length_q, length_d;
    logic [RDMA_LENGTH_WIDTH-1:0]   offset_q, offset_d;
    logic [RDMA_LENGTH_WIDTH-1:0]   remaining_q, remaining_d;
    logic [RDMA_LENGTH_WIDTH-1:0]   frag_len_q, frag_len_d;
    logic                           first_q, first_d;
    logic                           last_q, last_d;
    logic [3:0]                     frag_idx_q, frag_idx_d;
    logic [7:0]                     hdr_opcode_q, hdr_opcode_d;
    logic [RDMA_ADDR_WIDTH-1:0]     hdr_remote_addr_q, hdr_remote_addr_d;
    logic [RDMA_RKEY_WIDTH-1:0]     hdr_rkey_q, hdr_rkey_d;
    logic [RDMA_LENGTH_WIDTH-1:0]   hdr_length_q, hdr_length_d;
    logic [OFFSET_LENGTH-1:0]       hdr_frag_off_q, hdr_frag_off_d;
    logic [71:0]                    tdata_q, tdata_d;

    logic [RDMA_LENGTH_WIDTH-1:0]   w_frag_len;
    logic                           w_last;
    logic                           w_length_ok;
    logic [C_ADDR_WIDTH-1:0]        w_saddr;
    logic [C_BTT_WIDTH-1:0]         w_btt;

    assign w_frag_len  = (remaining_q < c_mtu) ? remaining_q : c_mtu;
    assign w_last      = (remaining_q <= c_mtu);
    assign w_length_ok = (length_q != '0) && (length_q <= c_max_len);
    assign w_saddr     = local_addr_q + C_ADDR_WIDTH'(offset_q);
    assign w_btt       = C_BTT_WIDTH'(w_frag_len);

    always_comb begin
        state_d           = state_q;
        local_addr_d      = local_addr_q;
        remote_addr_d     = remote_addr_q;
        rkey_d            = rkey_q;
        length_d          = length_q;
        offset_d          = offset_q;
        remaining_d       = remaining_q;
        frag_len_d        = frag_len_q;
        first_d           = first_q;
        last_d            = last_q;
        frag_idx_d        = frag_idx_q;
        hdr_opcode_d      = hdr_opcode_q;
        hdr_remote_addr_d = hdr_remote_addr_q;
        hdr_rkey_d        = hdr_rkey_q;
        hdr_length_d      = hdr_length_q;
        hdr_frag_off_d    = hdr_frag_off_q;
        tdata_d           = tdata_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    local_addr_d  = cmd_local_addr;
                    remote_addr_d = cmd_remote_addr;
                    rkey_d        = cmd_rkey;
                    length_d      = cmd_length;
                    offset_d      = '0;
                    remaining_d   = cmd_length;
                    first_d       = 1'b1;
                    frag_idx_d    = '0;
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = w_length_ok ? S_PREPARE : S_ERROR;
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            S_PREPARE: begin
                frag_len_d = w_frag_len;
                last_d     = w_last;
                if (first_q && w_last) begin
                    hdr_opcode_d = RDMA_OPCODE_WRITE_ONLY;
                end else if (first_q) begin
                    hdr_opcode_d = RDMA_OPCODE_WRITE_FIRST;
                end else if (w_last) begin
                    hdr_opcode_d = RDMA_OPCODE_WRITE_LAST;
                end else begin
                    hdr_opcode_d = RDMA_OPCODE_WRITE_MIDDLE;
                end
                // Receiver adds the fragment offset itself, so the base address is sent unchanged.
                hdr_remote_addr_d = remote_addr_q;
                hdr_rkey_d        = rkey_q;
                hdr_length_d      = w_frag_len;
                hdr_frag_off_d    = offset_q[OFFSET_LENGTH-1:0];
                tdata_d = {4'h0, frag_idx_q, 32'(w_saddr), 1'b0, 1'b1, 6'b0, 1'b1, 23'(w_btt)};
                state_d = S_SEND_HDR;
            end
            S_SEND_HDR: begin
                if (hdr_ready) begin
                    state_d = S_ISSUE_CMD;
                end
            end
            S_ISSUE_CMD: begin
                if (m_axis_mm2s_cmd_tready) begin
                    state_d = S_WAIT_CMPLT;
                end
            end
            S_WAIT_CMPLT: begin
                if (mm2s_rd_xfer_cmplt) begin
                    offset_d    = offset_q + frag_len_q;
                    remaining_d = remaining_q - frag_len_q;
                    first_d     = 1'b0;
                    frag_idx_d  = frag_idx_q + 4'd1;
                    state_d     = last_q ? S_DONE : S_PREPARE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q           <= S_IDLE;
            local_addr_q      <= '0;
            remote_addr_q     <= '0;
            rkey_q            <= '0;
            length_q          <= '0;
            offset_q          <= '0;
            remaining_q       <= '0;
            frag_len_q        <= '0;
            first_q           <= 1'b0;
            last_q            <= 1'b0;
            frag_idx_q        <= '0;
            hdr_opcode_q      <= '0;
            hdr_remote_addr_q <= '0;
            hdr_rkey_q        <= '0;
            hdr_length_q      <= '0;
            hdr_frag_off_q    <= '0;
            tdata_q           <= '0;
        end else begin
            state_q           <= state_d;
            local_addr_q      <= local_addr_d;
            remote_addr_q     <= remote_addr_d;
            rkey_q            <= rkey_d;
            length_q          <= length_d;
            offset_q          <= offset_d;
            remaining_q       <= remaining_d;
            frag_len_q        <= frag_len_d;
            first_q           <= first_d;
            last_q            <= last_d;
            frag_idx_q        <= frag_idx_d;
            hdr_opcode_q      <= hdr_opcode_d;
            hdr_remote_addr_q <= hdr_remote_addr_d;
            hdr_rkey_q        <= hdr_rkey_d;
            hdr_length_q      <= hdr_length_d;
            hdr_frag_off_q    <= hdr_frag_off_d;
            tdata_q           <= tdata_d;
        end
    end

    assign cmd_ready              = (state_q == S_IDLE);
    assign hdr_valid              = (state_q == S_SEND_HDR);
    assign m_axis_mm2s_cmd_tvalid = (state_q == S_ISSUE_CMD);
    assign hdr_opcode             = hdr_opcode_q;
    assign hdr_remote_addr        = hdr_remote_addr_q;
    assign hdr_rkey               = hdr_rkey_q;
    assign hdr_length             = hdr_length_q;
    assign hdr_fragment_offset    = hdr_frag_off_q;
    assign m_axis_mm2s_cmd_tdata  = tdata_q;
    assign tx_state               = state_q;
    assign tx_active              = (state_q != S_IDLE);
    assign write_started          = (state_q == S_CHECK) && w_length_ok;
    assign write_done             = (state_q == S_DONE);
    assign length_error           = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_tx_streamer.sv
`default_nettype none
// ============================================================================
// tb_tx_streamer: table-driven directed bench for tx_streamer.
// Revision: 1.0
// ============================================================================
module tb_tx_streamer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_local_addr = '0;
    logic [63:0] cmd_remote_addr = '0;
    logic [31:0] cmd_rkey = '0;
    logic [31:0] cmd_length = '0;
    logic        hdr_valid;
    logic        hdr_ready = 1'b0;
    logic [7:0]  hdr_opcode;
    logic [63:0] hdr_remote_addr;
    logic [31:0] hdr_rkey;
    logic [31:0] hdr_length;
    logic [15:0] hdr_fragment_offset;
    logic [71:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        cmplt = 1'b0;
    logic [2:0]  tx_state;
    logic        tx_active;
    logic        write_started;
    logic        write_done;
    logic        length_error;

    tx_streamer dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_local_addr         (cmd_local_addr),
        .cmd_remote_addr        (cmd_remote_addr),
        .cmd_rkey               (cmd_rkey),
        .cmd_length             (cmd_length),
        .hdr_valid              (hdr_valid),
        .hdr_ready              (hdr_ready),
        .hdr_opcode             (hdr_opcode),
        .hdr_remote_addr        (hdr_remote_addr),
        .hdr_rkey               (hdr_rkey),
        .hdr_length             (hdr_length),
        .hdr_fragment_offset    (hdr_fragment_offset),
        .m_axis_mm2s_cmd_tdata  (tdata),
        .m_axis_mm2s_cmd_tvalid (tvalid),
        .m_axis_mm2s_cmd_tready (tready),
        .mm2s_rd_xfer_cmplt     (cmplt),
        .tx_state               (tx_state),
        .tx_active              (tx_active),
        .write_started          (write_started),
        .write_done             (write_done),
        .length_error           (length_error)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0]      len;
        logic [31:0]      loc;
        logic [63:0]      rem;
        logic [31:0]      rkey;
        bit               err;
        int               n;
        logic [2:0][7:0]  op;
        logic [2:0][31:0] flen;
        logic [2:0][15:0] off;
        int               hs;
        int               cs;
        bit               sp;
        bit               ab;
    } vec_t;

    vec_t vec [10];
    int   total = 0;
    int   bad = 0;
    int   overlap = 0;

    always @(negedge aclk) if (hdr_valid && tvalid) overlap++;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] len, input logic [31:0] loc,
                                input logic [63:0] rem, input logic [31:0] rkey,
                                input bit err, input int n,
                                input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2,
                                input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                                input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] f2,
                                input int hs, input int cs, input bit sp, input bit ab);
        vec_t v;
        v.len = len; v.loc = loc; v.rem = rem; v.rkey = rkey; v.err = err; v.n = n;
        v.op[0] = o0; v.op[1] = o1; v.op[2] = o2;
        v.flen[0] = l0; v.flen[1] = l1; v.flen[2] = l2;
        v.off[0] = f0; v.off[1] = f1; v.off[2] = f2;
        v.hs = hs; v.cs = cs; v.sp = sp; v.ab = ab;
        return v;
    endfunction

    task automatic check_hdr(input vec_t v, input int f, input string tag);
        check({tag, "_opcode"}, 72'(hdr_opcode), 72'(v.op[f]));
        check({tag, "_length"}, 72'(hdr_length), 72'(v.flen[f]));
        check({tag, "_offset"}, 72'(hdr_fragment_offset), 72'(v.off[f]));
        check({tag, "_remote"}, 72'(hdr_remote_addr), 72'(v.rem));
        check({tag, "_rkey"}, 72'(hdr_rkey), 72'(v.rkey));
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        int          cnt;
        logic [31:0] saddr;
        logic [71:0] exp_td;
        v = vec[i];
        cmd_local_addr  = v.loc;
        cmd_remote_addr = v.rem;
        cmd_rkey        = v.rkey;
        cmd_length      = v.len;
        cmd_valid       = 1'b1;
        check("cmd_ready_idle", 72'(cmd_ready), 72'(1));
        step();
        cmd_valid = 1'b0;
        check("state_check", 72'(tx_state), 72'(1));
        check("cmd_ready_busy", 72'(cmd_ready), 72'(0));
        if (v.err) begin
            check("started_on_err", 72'(write_started), 72'(0));
            step();
            check("length_error", 72'(length_error), 72'(1));
            check("state_error", 72'(tx_state), 72'(7));
            check("err_no_hdr", 72'(hdr_valid), 72'(0));
            check("err_no_cmd", 72'(tvalid), 72'(0));
            step();
            check("err_pulse_once", 72'(length_error), 72'(0));
            check("err_back_idle", 72'(cmd_ready), 72'(1));
            check("err_hdr_quiet", 72'(hdr_valid), 72'(0));
            return;
        end
        check("write_started", 72'(write_started), 72'(1));
        step();
        check("state_prepare", 72'(tx_state), 72'(2));
        check("started_once", 72'(write_started), 72'(0));
        step();
        for (int f = 0; f < v.n; f++) begin
            cnt = 0;
            while (!hdr_valid && cnt < 20) begin
                step();
                cnt++;
            end
            check("hdr_valid", 72'(hdr_valid), 72'(1));
            check_hdr(v, f, "hdr");
            check("hdr_no_tvalid", 72'(tvalid), 72'(0));
            for (int s = 0; s < v.hs; s++) begin
                cmplt = v.sp && (s == 1);
                step();
                check("hdr_stall_valid", 72'(hdr_valid), 72'(1));
                check_hdr(v, f, "hdr_stall");
            end
            cmplt     = 1'b0;
            hdr_ready = 1'b1;
            step();
            hdr_ready = 1'b0;
            saddr  = v.loc + 32'(v.off[f]);
            exp_td = {4'h0, 4'(f), saddr, 1'b0, 1'b1, 6'b0, 1'b1, 23'(v.flen[f])};
            check("tvalid", 72'(tvalid), 72'(1));
            check("hdr_dropped", 72'(hdr_valid), 72'(0));
            check("tdata", tdata, exp_td);
            for (int s = 0; s < v.cs; s++) begin
                step();
                check("cmd_stall_valid", 72'(tvalid), 72'(1));
                check("cmd_stall_tdata", tdata, exp_td);
            end
            tready = 1'b1;
            step();
            tready = 1'b0;
            check("state_wait", 72'(tx_state), 72'(5));
            check("tvalid_dropped", 72'(tvalid), 72'(0));
            if (v.ab) return;
            step();
            check("still_waiting", 72'(tx_state), 72'(5));
            cmplt = 1'b1;
            step();
            cmplt = 1'b0;
            if (f == v.n - 1) begin
                check("write_done", 72'(write_done), 72'(1));
                check("state_done", 72'(tx_state), 72'(6));
                step();
                check("done_once", 72'(write_done), 72'(0));
                check("done_idle", 72'(cmd_ready), 72'(1));
                check("done_inactive", 72'(tx_active), 72'(0));
            end else begin
                check("next_prepare", 72'(tx_state), 72'(2));
                check("no_early_done", 72'(write_done), 72'(0));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec[0] = mk(32'd256, 32'h1000_0000, 64'h2000_0000, 32'hCAFE_0001, 0, 1,
                    8'h0A, 8'h00, 8'h00, 32'd256, 32'd0, 32'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0);
        vec[1] = mk(32'd2500, 32'h1000_0000, 64'h0000_0001_2000_0000, 32'hCAFE_0002, 0, 3,
                    8'h06, 8'h07, 8'h08, 32'd1024, 32'd1024, 32'd452, 16'd0, 16'd1024, 16'd2048, 0, 0, 0, 0);
        vec[2] = mk(32'd2048, 32'h0000_4000, 64'h3000_0000, 32'hCAFE_0003, 0, 2,
                    8'h06, 8'h08, 8'h00, 32'd1024, 32'd1024, 32'd0, 16'd0, 16'd1024, 16'd0, 0, 0, 0, 0);
        vec[3] = mk(32'd0, 32'h0, 64'h0, 32'h0, 1, 0,
                    8'h00, 8'h00, 8'h00, 32'd0, 32'd0, 32'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0);
        vec[4] = mk(32'd70000, 32'h0, 64'h0, 32'h0, 1, 0,
                    8'h00, 8'h00, 8'h00, 32'd0, 32'd0, 32'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0);
        vec[5] = mk(32'd65537, 32'h0, 64'h0, 32'h0, 1, 0,
                    8'h00, 8'h00, 8'h00, 32'd0, 32'd0, 32'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0);
        vec[6] = mk(32'd1024, 32'h0000_8000, 64'h4000_0000, 32'hCAFE_0006, 0, 1,
                    8'h0A, 8'h00, 8'h00, 32'd1024, 32'd0, 32'd0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0);
        vec[7] = mk(32'd1025, 32'h0000_8000, 64'h4000_1000, 32'hCAFE_0007, 0, 2,
                    8'h06, 8'h08, 8'h00, 32'd1024, 32'd1, 32'd0, 16'd0, 16'd1024, 16'd0, 0, 0, 0, 0);
        vec[8] = mk(32'd1500, 32'hFFFF_FF00, 64'h5000_0000, 32'hCAFE_0008, 0, 2,
                    8'h06, 8'h08, 8'h00, 32'd1024, 32'd476, 32'd0, 16'd0, 16'd1024, 16'd0, 5, 3, 1, 0);
        vec[9] = mk(32'd2500, 32'h1000_0000, 64'h2000_0000, 32'hCAFE_0009, 0, 3,
                    8'h06, 8'h07, 8'h08, 32'd1024, 32'd1024, 32'd452, 16'd0, 16'd1024, 16'd2048, 0, 0, 0, 1);

        step();
        step();
        check("rst_hdr_valid", 72'(hdr_valid), 72'(0));
        check("rst_tvalid", 72'(tvalid), 72'(0));
        check("rst_tdata", tdata, 72'(0));
        check("rst_opcode", 72'(hdr_opcode), 72'(0));
        check("rst_state", 72'(tx_state), 72'(0));
        check("rst_active", 72'(tx_active), 72'(0));
        check("rst_pulses", 72'({write_started, write_done, length_error}), 72'(0));
        aresetn = 1'b1;
        step();
        check("rst_cmd_ready", 72'(cmd_ready), 72'(1));

        for (int i = 0; i < 10; i++) begin
            run_vec(i);
            step();
        end

        // Vector 9 stops in WAIT_CMPLT of its first fragment; reset it there.
        aresetn = 1'b0;
        step();
        check("midrst_state", 72'(tx_state), 72'(0));
        check("midrst_active", 72'(tx_active), 72'(0));
        check("midrst_hdr_valid", 72'(hdr_valid), 72'(0));
        check("midrst_tvalid", 72'(tvalid), 72'(0));
        check("midrst_tdata", tdata, 72'(0));
        check("midrst_opcode", 72'(hdr_opcode), 72'(0));
        check("midrst_length", 72'(hdr_length), 72'(0));
        aresetn = 1'b1;
        step();
        check("midrst_cmd_ready", 72'(cmd_ready), 72'(1));
        run_vec(0);

        check("no_hdr_cmd_overlap", 72'(overlap), 72'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
